// File: rtl/adder_ins_packer.sv
// rtl/adder_ins_packer.sv - packs a byte stream into the {cin,w,z,y,x} adder operand word
// Optional ADDER_PACK_SUM_EN adds a registered reference sum of the completed word.
module adder_ins_packer #(
  parameter int BYTE_W = 8,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BYTE_W-1:0]       in_data,
  input  logic                    in_cin,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [LANES*BYTE_W:0]   ins,
  output logic                    ins_valid,
  input  logic                    ins_ready
`ifdef ADDER_PACK_SUM_EN
  ,
  output logic [BYTE_W+1:0]       sum_r,
  output logic                    sum_zero_r
`endif
);

  localparam int W     = LANES*BYTE_W + 1;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES-1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] lane_cnt_q, lane_cnt_d;
  logic [W-1:0]     ins_q, ins_d;
  logic             ins_valid_q, ins_valid_d;
  logic             complete;

  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q;
    in_ready    = 1'b1;
    complete    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (flush) begin
          lane_cnt_d = '0;
        end else if (in_valid) begin
          ins_d[lane_cnt_q*BYTE_W +: BYTE_W] = in_data;
          if (lane_cnt_q == LAST_LANE) begin
            ins_d[W-1]  = in_cin;
            lane_cnt_d  = '0;
            ins_valid_d = 1'b1;
            state_d     = HOLD;
            complete    = 1'b1;
          end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // Ready follows the consumer so a byte can enter as the held word leaves.
        in_ready = ins_ready;
        if (ins_ready) begin
          ins_valid_d = 1'b0;
          state_d     = COLLECT;
          lane_cnt_d  = '0;
          if (!flush && in_valid) begin
            ins_d[BYTE_W-1:0] = in_data;
            if (LANES == 1) begin
              ins_d[W-1]  = in_cin;
              ins_valid_d = 1'b1;
              state_d     = HOLD;
              complete    = 1'b1;
            end else begin
              lane_cnt_d = CNT_W'(1);
            end
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      lane_cnt_q  <= '0;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
    end
  end

  assign ins       = ins_q;
  assign ins_valid = ins_valid_q;

`ifdef ADDER_PACK_SUM_EN
  logic [BYTE_W+1:0] sum_q, sum_d, sum_acc;
  logic              sum_zero_q, sum_zero_d;

  // Sum is taken from the word as it will be after this edge, so it lines up with ins_valid.
  always_comb begin
    sum_acc = {{(BYTE_W+1){1'b0}}, ins_d[W-1]};
    for (int i = 0; i < LANES; i++) begin
      sum_acc = sum_acc + {2'b00, ins_d[i*BYTE_W +: BYTE_W]};
    end
    sum_d      = sum_q;
    sum_zero_d = sum_zero_q;
    if (complete) begin
      sum_d      = sum_acc;
      sum_zero_d = (sum_acc == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      sum_zero_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      sum_zero_q <= sum_zero_d;
    end
  end

  assign sum_r      = sum_q;
  assign sum_zero_r = sum_zero_q;
`endif

endmodule

// File: tb/tb_adder_ins_packer.sv
// tb/tb_adder_ins_packer.sv - directed bench with a byte-list model of the operand packer
module tb_adder_ins_packer;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_cin = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        ins_ready = 1'b0;
  logic        in_ready;
  logic        ins_valid;
  logic [32:0] ins;
`ifdef ADDER_PACK_SUM_EN
  logic [9:0]  sum_r;
  logic        sum_zero_r;
`endif

  adder_ins_packer #(.BYTE_W(BYTE_W), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_cin(in_cin),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready)
`ifdef ADDER_PACK_SUM_EN
    , .sum_r(sum_r), .sum_zero_r(sum_zero_r)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word is pending or not; bytes of the current word are kept as a list.
  bit          m_pending = 1'b0;
  int          m_n = 0;
  logic [7:0]  m_bytes [LANES];
  logic [32:0] m_word = '0;
  int          m_sum = 0;
  bit          m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 1'b0;
      m_n       = 0;
      m_word    = '0;
      m_sum     = 0;
    end else begin
      m_rdy = !m_pending || ins_ready;
      if (m_pending && ins_ready) m_pending = 1'b0;
      if (m_rdy) begin
        if (flush) begin
          m_n = 0;
        end else if (in_valid) begin
          m_bytes[m_n] = in_data;
          m_n++;
          if (m_n == LANES) begin
            m_sum = int'(in_cin);
            for (int i = 0; i < LANES; i++) begin
              m_word[i*8 +: 8] = m_bytes[i];
              m_sum += int'(m_bytes[i]);
            end
            m_word[32] = in_cin;
            m_pending  = 1'b1;
            m_n        = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("ins_valid", 64'(ins_valid), 64'(m_pending));
    check("in_ready", 64'(in_ready), 64'(!m_pending || ins_ready));
    if (m_pending) check("ins", 64'(ins), 64'(m_word));
`ifdef ADDER_PACK_SUM_EN
    check("sum_r", 64'(sum_r), 64'(m_sum));
    check("sum_zero_r", 64'(sum_zero_r), 64'(m_sum == 0));
`endif
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] d, input logic c);
    in_data  = d;
    in_cin   = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_ins_valid", 64'(ins_valid), 64'd0);
    check("rst_ins", 64'(ins), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    ins_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_ins_valid", 64'(ins_valid), 64'd0);
    check("post_rst_ins", 64'(ins), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Basic word
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
    check("t2_valid", 64'(ins_valid), 64'd1);
    check("t2_ins", 64'(ins), 64'h1_4433_2211);
`ifdef ADDER_PACK_SUM_EN
    check("t2_sum", 64'(sum_r), 64'h0AB);
    check("t2_zero", 64'(sum_zero_r), 64'd0);
`endif
    step();
    check("t2_valid_drop", 64'(ins_valid), 64'd0);

    // Held word with backpressure, then a byte enters as the word leaves
    ins_ready = 1'b0;
    send(8'hA0, 1'b0); send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
    in_data = 8'h55; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_ins", 64'(ins), 64'h0_A3A2_A1A0);
      check("t3_hold_ready", 64'(in_ready), 64'd0);
      step();
    end
    ins_ready = 1'b1;
    send(8'hAA, 1'b1);
    check("t3_left", 64'(ins_valid), 64'd0);
    send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b1);
    check("t3_ins", 64'(ins), 64'h1_DDCC_BBAA);

    // Back-to-back words
    for (int k = 0; k < 8; k++) begin
      send(8'hFF, 1'b1);
      if (k == 3 || k == 7) begin
        check("t4_ins", 64'(ins), 64'h1_FFFF_FFFF);
`ifdef ADDER_PACK_SUM_EN
        check("t4_sum", 64'(sum_r), 64'h3FD);
`endif
      end
      if (k == 4) check("t4_gap", 64'(ins_valid), 64'd0);
    end
    step();

    // Flush drops the partial word; cin on early lanes is ignored
    send(8'h77, 1'b1); send(8'h66, 1'b1);
    flush = 1'b1;
    send(8'h99, 1'b1);
    flush = 1'b0;
    send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h04, 1'b0);
    check("t5_ins", 64'(ins), 64'h0_0403_0201);
    step();
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    check("t5_zero_word", 64'(ins), 64'd0);
`ifdef ADDER_PACK_SUM_EN
    check("t5_sum_zero", 64'(sum_zero_r), 64'd1);
`endif
    step();

    // Flush while holding keeps the word; flush with ready drops the byte
    ins_ready = 1'b0;
    send(8'h21, 1'b0); send(8'h43, 1'b0); send(8'h65, 1'b0); send(8'h87, 1'b1);
    flush = 1'b1;
    step(); step();
    check("hold_flush_valid", 64'(ins_valid), 64'd1);
    check("hold_flush_ins", 64'(ins), 64'h1_8765_4321);
    ins_ready = 1'b1;
    send(8'hEE, 1'b0);
    flush = 1'b0;
    send(8'h0A, 1'b0); send(8'h0B, 1'b0); send(8'h0C, 1'b0); send(8'h0D, 1'b0);
    check("flush_ready_ins", 64'(ins), 64'h0_0D0C_0B0A);
    step();

    // Async reset mid-word
    send(8'h31, 1'b0); send(8'h32, 1'b0); send(8'h33, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(ins_valid), 64'd0);
    check("t6_rst_ins", 64'(ins), 64'd0);
    check("t6_rst_ready", 64'(in_ready), 64'd1);
    #1 rst_n = 1'b1;
    step();
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b1);
    check("t6_ins", 64'(ins), 64'h1_4030_2010);
    check("t6_valid", 64'(ins_valid), 64'd1);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
